// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory sequencer: turns loads/stores into one req/ack bus transaction,
// lane-aligns store data, extends load data and stalls the pipeline while the access is open.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        memory_busy,
    output logic        misaligned,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int unsigned TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (TO_BITS > 8) ? TO_BITS : 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [31:0]      bus_addr_q, bus_addr_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [3:0]       bus_wstrb_q, bus_wstrb_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             bus_error_q, bus_error_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       f3_q, f3_d;

    logic             op;
    logic [3:0]       st_strb;
    logic [31:0]      st_data;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign op = (mem_read | mem_write) & ~misaligned;

    always_comb begin
        st_strb = 4'b1111;
        st_data = wdata;
        case (funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << addr[1:0];
                st_data = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        rdata_d     = rdata_q;
        bus_error_d = 1'b0;
        cnt_d       = cnt_q;
        off_d       = off_q;
        f3_d        = f3_q;
        memory_busy = 1'b0;
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                memory_busy = op;
                if (op) begin
                    state_d     = WAIT;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_wdata_d = st_data;
                    bus_wstrb_d = mem_write ? st_strb : 4'b0000;
                    off_d       = addr[1:0];
                    f3_d        = funct3;
                    cnt_d       = '0;
                end
            end
            WAIT: begin
                memory_busy = 1'b1;
                cnt_d       = cnt_inc;
                // A completing ack wins over an abort landing in the same cycle.
                if (bus_ack) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    rdata_d   = bus_we_q ? 32'd0 : load_extend(f3_q, off_q, bus_rdata);
                end else if (TIMEOUT_EN && (cnt_inc >= CNT_LIMIT)) begin
                    state_d     = RESP;
                    bus_req_d   = 1'b0;
                    rdata_d     = 32'd0;
                    bus_error_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_wstrb_q <= 4'b0000;
            rdata_q     <= 32'd0;
            bus_error_q <= 1'b0;
            cnt_q       <= '0;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            rdata_q     <= rdata_d;
            bus_error_q <= bus_error_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
        end
    end

    assign rdata     = rdata_q;
    assign bus_error = bus_error_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized bench for dmem_access_unit: a transaction-level model sets per-cycle
// expectations and one negedge process compares them, plus literal directed checks.
module tb_dmem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        memory_busy, misaligned, bus_error;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .memory_busy(memory_busy), .misaligned(misaligned), .bus_error(bus_error),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model: access size, alignment, lanes, extension ----
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic mis_of(input logic [2:0] f3, input logic [31:0] a);
        return (a % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] strb_of(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << size_of(f3)) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] wd);
        if (size_of(f3) == 1) return wd[7:0] * 32'h01010101;
        if (size_of(f3) == 2) return wd[15:0] * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] load_of(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
        longint unsigned sz, r, v;
        sz = longint'(size_of(f3));
        r  = rd;
        v  = (r >> (8 * (a % 4))) & ((64'd1 << (8 * sz)) - 1);
        if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1)))
            v = v - (64'd1 << (8 * sz));
        return 32'(v);
    endfunction

    // ---- per-cycle expectations written by the driver, checked at negedge ----
    logic        chk_en = 1'b0;
    logic        e_mis, e_busy, e_req, e_err, e_we;
    logic        c_bus = 1'b0, c_wdata = 1'b0, c_rdata = 1'b0;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_strb;
    int          busy_cnt = 0, req_cnt = 0, err_cnt = 0;
    logic [31:0] last_rdata, seen_addr, seen_wdata;
    logic [3:0]  seen_strb;
    logic        seen_we, last_mis;

    always @(negedge clk) begin
        if (memory_busy === 1'b1) busy_cnt++;
        if (bus_error === 1'b1) err_cnt++;
        if (bus_req === 1'b1) begin
            req_cnt++;
            seen_addr  = bus_addr;
            seen_wdata = bus_wdata;
            seen_strb  = bus_wstrb;
            seen_we    = bus_we;
        end
        last_mis = misaligned;
        if (chk_en) begin
            check("misaligned", misaligned, e_mis);
            check("memory_busy", memory_busy, e_busy);
            check("bus_req", bus_req, e_req);
            check("bus_error", bus_error, e_err);
            if (c_bus) begin
                check("bus_addr", bus_addr, e_addr);
                check("bus_we", bus_we, e_we);
                check("bus_wstrb", bus_wstrb, e_strb);
            end
            if (c_wdata) check("bus_wdata", bus_wdata, e_wdata);
            if (c_rdata) begin
                check("rdata", rdata, e_rdata);
                last_rdata = rdata;
            end
        end
    end

    task automatic idle_cycle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bus_ack   = 1'($urandom % 2);
        bus_rdata = $urandom;
        e_mis = mis_of(funct3, addr); e_busy = 1'b0; e_req = 1'b0; e_err = 1'b0;
        c_bus = 1'b0; c_wdata = 1'b0; c_rdata = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
    endtask

    // ack_k: WAIT cycle (1-based) in which ack is offered; 0 = never (timeout)
    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int ack_k, input logic [31:0] brd);
        logic mis, op, tmo;
        int   waits;
        mis   = mis_of(f3, a);
        op    = (rd | wr) & ~mis;
        tmo   = (ack_k == 0);
        waits = tmo ? TO : ack_k;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        bus_ack   = 1'($urandom % 2);
        bus_rdata = $urandom;
        e_mis = mis; e_busy = op; e_req = 1'b0; e_err = 1'b0;
        c_bus = 1'b0; c_wdata = 1'b0; c_rdata = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        if (!op) return;
        for (int k = 1; k <= waits; k++) begin
            bus_ack   = (k == ack_k);
            bus_rdata = (k == ack_k) ? brd : $urandom;
            addr      = $urandom;
            wdata     = $urandom;
            e_mis  = mis_of(funct3, addr);
            e_busy = 1'b1; e_req = 1'b1; e_err = 1'b0;
            c_bus  = 1'b1; e_addr = a & ~32'd3; e_we = wr;
            e_strb = wr ? strb_of(f3, a) : 4'b0000;
            c_wdata = wr; e_wdata = wdata_of(f3, wd);
            @(posedge clk); #1;
        end
        bus_ack   = 1'b1;
        bus_rdata = $urandom;
        e_busy = 1'b0; e_req = 1'b0; e_err = tmo;
        c_bus = 1'b0; c_wdata = 1'b0; c_rdata = 1'b1;
        e_rdata = (wr || tmo) ? 32'd0 : load_of(f3, a, brd);
        @(posedge clk); #1;
        c_rdata = 1'b0;
        bus_ack = 1'b0;
    endtask

    logic [2:0]  lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic        r_rd, r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_a;
    int          r_k;

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_wstrb", bus_wstrb, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", memory_busy, 0);
        check("rst_bus_error", bus_error, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // model pins
        check("model_lb", load_of(3'b000, 32'h103, 32'h80FFFFFF), 32'hFFFFFF80);
        check("model_sh_strb", strb_of(3'b001, 32'h202), 4'b1100);

        // 1: LW, ack on the third request cycle
        busy_cnt = 0;
        txn(1, 0, 3'b010, 32'h100, 0, 3, 32'hDEADBEEF);
        check("t1_busy_cycles", busy_cnt, 4);
        check("t1_rdata", last_rdata, 32'hDEADBEEF);

        // 2: LB / LBU top byte
        txn(1, 0, 3'b000, 32'h103, 0, 1, 32'h80FFFFFF);
        check("t2_lb", last_rdata, 32'hFFFFFF80);
        txn(1, 0, 3'b100, 32'h103, 0, 2, 32'h80FFFFFF);
        check("t2_lbu", last_rdata, 32'h00000080);

        // 3: SH upper half
        txn(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 2, 32'h0);
        check("t3_addr", seen_addr, 32'h200);
        check("t3_strb", seen_strb, 4'b1100);
        check("t3_wdata", seen_wdata, 32'hABCDABCD);
        check("t3_we", seen_we, 1);

        // 4: misaligned LW issues nothing
        busy_cnt = 0; req_cnt = 0;
        txn(1, 0, 3'b010, 32'h101, 0, 1, 32'h0);
        check("t4_mis", last_mis, 1);
        idle_cycle();
        check("t4_busy", busy_cnt, 0);
        check("t4_req", req_cnt, 0);

        // 5: no ack -> timeout abort
        busy_cnt = 0; err_cnt = 0;
        txn(1, 0, 3'b010, 32'h40, 0, 0, 32'h0);
        idle_cycle();
        check("t5_err_pulses", err_cnt, 1);
        check("t5_rdata", last_rdata, 0);
        check("t5_busy_cycles", busy_cnt, 1 + TO);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            r_rd = 1'($urandom % 2);
            r_wr = 1'($urandom % 2);
            r_f3 = r_wr ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
            r_a  = $urandom;
            if ($urandom % 4 != 0) r_a = r_a - (r_a % size_of(r_f3));
            r_k  = $urandom % 5;
            if (r_k == 4) r_k = 1;
            txn(r_rd, r_wr, r_f3, r_a, $urandom, r_k, $urandom);
            if ($urandom % 3 == 0) idle_cycle();
        end

        // 6: reset in WAIT, then a late ack
        chk_en = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300; bus_ack = 1'b0;
        @(posedge clk); #1;
        mem_read = 1'b0;
        check("t6_req_in_wait", bus_req, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_req_after_rst", bus_req, 0);
        check("t6_busy_after_rst", memory_busy, 0);
        bus_ack = 1'b1; bus_rdata = 32'h55555555;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("t6_late_ack_req", bus_req, 0);
            check("t6_late_ack_busy", memory_busy, 0);
            check("t6_late_ack_err", bus_error, 0);
            check("t6_late_ack_rdata", rdata, 0);
        end
        bus_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
